muldiv_unit: RTL and testbench

- Multi-cycle integer multiply/divide unit for the execute stage; owns the architectural HI/LO registers.
- The execute stage issues MULT/MULTU/DIV/DIVU with a start pulse, holds the pipeline while `busy`, and reads HI/LO for MFHI/MFLO.
- MTHI/MTLO write HI/LO directly.
- Implements a 32-iteration shift-add multiplier and a restoring divider sharing one 64-bit working register.

---
 rtl/muldiv_unit.sv | 204 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Ports: clock, reset (async, active-low), start/op/Read_data_1/Read_data_2 issue an op,
//   hi_we/lo_we write HI/LO (MTHI/MTLO) from Read_data_1, flush aborts the op in flight.
//   Outputs: busy, done (1-cycle pulse), HI, LO, div_by_zero (valid with done).
// Define MDU_DIV_EN to build the restoring divider; otherwise DIV/DIVU complete in
//   one cycle and leave HI/LO untouched.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] Read_data_1,
    input  logic [WIDTH-1:0] Read_data_2,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SIGN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W2-1:0]    work_q, work_d;
    // Multiplicand magnitude for MULT*, divisor magnitude for DIV*.
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             div_q, div_d;
    logic             qneg_q, qneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
`ifdef MDU_DIV_EN
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] aorig_q, aorig_d;
`endif

    logic             sgn_op;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   madd;
    logic [W2-1:0]    mul_step;
    logic [W2-1:0]    prod_fix;

    assign sgn_op = ~op[0];
    assign a_mag  = (sgn_op && Read_data_1[WIDTH-1]) ? -Read_data_1 : Read_data_1;
    assign b_mag  = (sgn_op && Read_data_2[WIDTH-1]) ? -Read_data_2 : Read_data_2;

    // Shift-add: add multiplicand into the upper half when the multiplier
    // LSB is set, then shift the whole {acc, multiplier} right by one.
    assign madd     = {1'b0, work_q[W2-1:WIDTH]}
                    + (work_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_step = {madd, work_q[WIDTH-1:1]};
    assign prod_fix = qneg_q ? -work_q : work_q;

`ifdef MDU_DIV_EN
    // Restoring divide: the shifted partial remainder needs WIDTH+1 bits;
    // after a successful subtract it always fits back into WIDTH bits.
    logic [WIDTH:0]   rsh;
    logic             ge;
    logic [WIDTH-1:0] rsub;
    logic [W2-1:0]    div_step;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign rsh      = work_q[W2-1:WIDTH-1];
    assign ge       = (rsh >= {1'b0, opnd_q});
    assign rsub     = rsh[WIDTH-1:0] - opnd_q;
    assign div_step = {(ge ? rsub : rsh[WIDTH-1:0]), work_q[WIDTH-2:0], ge};
    assign q_fix    = qneg_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    assign r_fix    = rneg_q ? -work_q[W2-1:WIDTH] : work_q[W2-1:WIDTH];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        qneg_d  = qneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
`ifdef MDU_DIV_EN
        rneg_d  = rneg_q;
        aorig_d = aorig_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = Read_data_1;
                if (lo_we) lo_d = Read_data_1;
                if (start && !flush) begin
                    cnt_d  = '0;
                    div_d  = op[1];
                    qneg_d = sgn_op & (Read_data_1[WIDTH-1] ^ Read_data_2[WIDTH-1]);
                    dbz_d  = 1'b0;
                    if (op[1]) begin
                        opnd_d = b_mag;
                        work_d = {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        opnd_d = a_mag;
                        work_d = {{WIDTH{1'b0}}, b_mag};
                    end
`ifdef MDU_DIV_EN
                    rneg_d  = sgn_op & Read_data_1[WIDTH-1];
                    aorig_d = Read_data_1;
                    state_d = S_CALC;
`else
                    // No divider: a divide goes straight to the finish state.
                    state_d = op[1] ? S_SIGN : S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
`ifdef MDU_DIV_EN
                    work_d = div_q ? div_step : mul_step;
`else
                    work_d = mul_step;
`endif
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!div_q) begin
                        hi_d = prod_fix[W2-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
`ifdef MDU_DIV_EN
                    else if (opnd_q == '0) begin
                        hi_d  = aorig_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        hi_d = r_fix;
                        lo_d = q_fix;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef MDU_DIV_EN
            rneg_q  <= 1'b0;
            aorig_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef MDU_DIV_EN
            rneg_q  <= rneg_d;
            aorig_q <= aorig_d;
`endif
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign HI          = hi_q;
    assign LO          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed + randomized checks of muldiv_unit against an
// arithmetic reference model (64-bit products, native signed/unsigned divide).
module tb_muldiv_unit;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] Read_data_1 = '0;
    logic [31:0] Read_data_2 = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_dbz = 1'b0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .Read_data_1(Read_data_1), .Read_data_2(Read_data_2),
        .hi_we(hi_we), .lo_we(lo_we), .flush(flush),
        .busy(busy), .done(done), .HI(HI), .LO(LO),
        .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural result of one op, from plain arithmetic.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        m_dbz = 1'b0;
        case (o)
            2'b00: begin
                p = 64'(sa * sb);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            default: begin
                if (DIV_EN) begin
                    if (b == 32'd0) begin
                        m_hi = a;
                        m_lo = 32'hFFFF_FFFF;
                        m_dbz = 1'b1;
                    end else if (o == 2'b10) begin
                        q = sa / sb;
                        r = sa % sb;
                        m_lo = q[31:0];
                        m_hi = r[31:0];
                    end else begin
                        m_lo = a / b;
                        m_hi = a % b;
                    end
                end
            end
        endcase
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        int lat, exp_lat;
        start = 1'b1;
        op = o;
        Read_data_1 = a;
        Read_data_2 = b;
        @(posedge clock);
        #1;
        start = 1'b0;
        op = 2'($urandom);
        Read_data_1 = $urandom;
        Read_data_2 = $urandom;
        check({tag, " busy"}, 64'(busy), 64'd1);
        model(o, a, b);
        exp_lat = (o[1] && !DIV_EN) ? 1 : 33;
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!done && lat < 40);
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        check({tag, " HI"}, 64'(HI), 64'(m_hi));
        check({tag, " LO"}, 64'(LO), 64'(m_lo));
        check({tag, " dbz"}, 64'(div_by_zero), 64'(m_dbz));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic seen;
        #2 reset = 1'b0;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst HI", 64'(HI), 64'd0);
        check("rst LO", 64'(LO), 64'd0);
        check("rst dbz", 64'(div_by_zero), 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        check("multu_max HI const", 64'(HI), 64'hFFFF_FFFE);
        check("multu_max LO const", 64'(LO), 64'h0000_0001);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg");
        check("mult_neg LO const", 64'(LO), 64'hFFFF_FFEB);
        // issued from inside the done cycle
        run_op(2'b00, 32'd2, 32'd3, "mult_b2b");
        @(posedge clock);
        #1;
        check("done one cycle", 64'(done), 64'd0);

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg");
        run_op(2'b11, 32'd100, 32'd7, "divu");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_wrap");
        run_op(2'b11, 32'd100, 32'd0, "divu_zero");
        run_op(2'b10, 32'hFFFF_FFF0, 32'd0, "div_zero");
        run_op(2'b01, 32'd3, 32'd4, "multu_clr");
        run_op(2'b11, 32'd8, 32'd2, "divu_8_2");

        // flush sequence with an ignored start and MTHI while busy
        run_op(2'b01, 32'd11, 32'd13, "pre_flush");
        start = 1'b1; op = 2'b01; Read_data_1 = 32'd5; Read_data_2 = 32'd6;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        start = 1'b1; op = 2'b01; Read_data_1 = 32'd9; Read_data_2 = 32'd9; hi_we = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0; hi_we = 1'b0;
        check("busy hi_we ignored", 64'(HI), 64'(m_hi));
        repeat (5) @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done) seen = 1'b1;
        end
        check("flush no done", 64'(seen), 64'd0);
        check("flush HI", 64'(HI), 64'(m_hi));
        check("flush LO", 64'(LO), 64'(m_lo));
        lo_we = 1'b1; Read_data_1 = 32'h1234;
        @(posedge clock);
        #1;
        lo_we = 1'b0;
        check("mtlo LO", 64'(LO), 64'h1234);
        m_lo = 32'h1234;

        // start with flush in IDLE is dropped
        start = 1'b1; flush = 1'b1; op = 2'b01;
        @(posedge clock);
        #1;
        start = 1'b0; flush = 1'b0;
        check("idle flush start", 64'(busy), 64'd0);

        // MTHI together with start: write now, product later
        start = 1'b1; hi_we = 1'b1; op = 2'b01;
        Read_data_1 = 32'hABCD; Read_data_2 = 32'd2;
        @(posedge clock);
        #1;
        start = 1'b0; hi_we = 1'b0;
        check("mthi+start HI", 64'(HI), 64'hABCD);
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done) break;
        end
        model(2'b01, 32'hABCD, 32'd2);
        check("mthi+start done", 64'(done), 64'd1);
        check("mthi+start HI res", 64'(HI), 64'(m_hi));
        check("mthi+start LO res", 64'(LO), 64'(m_lo));

        for (int i = 0; i < 30; i++) begin
            run_op(2'($urandom), pick(), pick(), $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clock);
                #1;
                check($sformatf("rnd%0d pulse", i), 64'(done), 64'd0);
            end
        end

        // async reset mid-operation
        start = 1'b1; op = DIV_EN ? 2'b10 : 2'b00;
        Read_data_1 = 32'h1234_5678; Read_data_2 = 32'd3;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst HI", 64'(HI), 64'd0);
        check("midrst LO", 64'(LO), 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
